// File: rtl/uart_frame_ctrl.sv
// Frame decoder behind a UART receiver: SYNC, CMD, LEN, payload, additive CHK.
// Good frames are latched on the outputs; errors and timeouts only pulse a flag.
module uart_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 8,
    parameter int         TIMEOUT_CLKS = 131580
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic                   i_Rx_DV,
    input  logic [7:0]             i_Rx_Byte,
    output logic                   o_Frame_Valid,
    output logic [7:0]             o_Cmd,
    output logic [3:0]             o_Len,
    output logic [8*MAX_LEN-1:0]   o_Payload,
    output logic                   o_Err_Chk,
    output logic                   o_Err_Len,
    output logic                   o_Err_Timeout,
    output logic                   o_Busy
);

    localparam int TW = ($clog2(TIMEOUT_CLKS + 1) > 24) ? $clog2(TIMEOUT_CLKS + 1) : 24;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 2);
    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [7:0]    LEN_LIMIT  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    state_t          state_reg;
    logic [7:0]      acc_reg;
    logic [3:0]      idx_reg;
    logic [7:0]      shadow_cmd_reg;
    logic [3:0]      shadow_len_reg;
    logic [TW-1:0]   timer_reg;
    logic [7:0]      cmd_reg;
    logic [3:0]      len_reg;
    logic            frame_valid_reg;
    logic            err_chk_reg;
    logic            err_len_reg;
    logic            err_timeout_reg;
    logic [7:0]      shadow_payload_reg [MAX_LEN];
    logic [7:0]      payload_reg        [MAX_LEN];

    logic payload_clr;
    logic payload_wr;
    logic commit;

    assign payload_clr = i_Rx_DV && (state_reg == ST_IDLE) && (i_Rx_Byte == SYNC_BYTE);
    assign payload_wr  = i_Rx_DV && (state_reg == ST_PAYLOAD);
    assign commit      = i_Rx_DV && (state_reg == ST_CHK) && (i_Rx_Byte == acc_reg);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg       <= ST_IDLE;
            acc_reg         <= '0;
            idx_reg         <= '0;
            shadow_cmd_reg  <= '0;
            shadow_len_reg  <= '0;
            timer_reg       <= '0;
            cmd_reg         <= '0;
            len_reg         <= '0;
            frame_valid_reg <= 1'b0;
            err_chk_reg     <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            err_chk_reg     <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            if (i_Rx_DV) begin
                // A byte always wins over a timeout expiring in the same cycle.
                timer_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (i_Rx_Byte == SYNC_BYTE) begin
                            state_reg <= ST_CMD;
                            acc_reg   <= '0;
                            idx_reg   <= '0;
                        end
                    end
                    ST_CMD: begin
                        shadow_cmd_reg <= i_Rx_Byte;
                        acc_reg        <= acc_reg + i_Rx_Byte;
                        state_reg      <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (i_Rx_Byte > LEN_LIMIT) begin
                            err_len_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else begin
                            shadow_len_reg <= i_Rx_Byte[3:0];
                            acc_reg        <= acc_reg + i_Rx_Byte;
                            state_reg      <= (i_Rx_Byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        acc_reg <= acc_reg + i_Rx_Byte;
                        idx_reg <= idx_reg + 4'd1;
                        if (idx_reg == shadow_len_reg - 4'd1) begin
                            state_reg <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (commit) begin
                            cmd_reg         <= shadow_cmd_reg;
                            len_reg         <= shadow_len_reg;
                            frame_valid_reg <= 1'b1;
                        end else begin
                            err_chk_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end else if (state_reg != ST_IDLE) begin
                // Fires on the clock where the idle count would reach TIMEOUT_CLKS-1.
                if (timer_reg == TIMER_LAST) begin
                    err_timeout_reg <= 1'b1;
                    state_reg       <= ST_IDLE;
                    timer_reg       <= '0;
                end else if (timer_reg != TIMER_MAX) begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end else begin
                timer_reg <= '0;
            end
        end
    end

    // Per-byte payload storage; a new SYNC wipes the shadow so unused bytes read zero.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_payload
            always_ff @(posedge i_Clock or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    shadow_payload_reg[gi] <= '0;
                    payload_reg[gi]        <= '0;
                end else begin
                    if (payload_clr) begin
                        shadow_payload_reg[gi] <= '0;
                    end else if (payload_wr && (idx_reg == 4'(gi))) begin
                        shadow_payload_reg[gi] <= i_Rx_Byte;
                    end
                    if (commit) begin
                        payload_reg[gi] <= shadow_payload_reg[gi];
                    end
                end
            end
            assign o_Payload[8*gi +: 8] = payload_reg[gi];
        end
    endgenerate

    assign o_Frame_Valid = frame_valid_reg;
    assign o_Cmd         = cmd_reg;
    assign o_Len         = len_reg;
    assign o_Err_Chk     = err_chk_reg;
    assign o_Err_Len     = err_len_reg;
    assign o_Err_Timeout = err_timeout_reg;
    assign o_Busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed frames for uart_frame_ctrl; expected pulses go into a queue that a
// negedge monitor drains, checking pulse kind, cycle and held output values.
module tb_uart_frame_ctrl;

    localparam int T_OUT = 40;
    localparam int ML    = 8;

    logic          clk;
    logic          rst_n;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          frame_valid;
    logic [7:0]    cmd;
    logic [3:0]    len;
    logic [8*ML-1:0] payload;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;
    logic          busy;

    uart_frame_ctrl #(
        .SYNC_BYTE    (8'hA5),
        .MAX_LEN      (ML),
        .TIMEOUT_CLKS (T_OUT)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Frame_Valid (frame_valid),
        .o_Cmd         (cmd),
        .o_Len         (len),
        .o_Payload     (payload),
        .o_Err_Chk     (err_chk),
        .o_Err_Len     (err_len),
        .o_Err_Timeout (err_timeout),
        .o_Busy        (busy)
    );

    typedef struct {
        int              kind;     // 0 frame, 1 chk, 2 len, 3 timeout
        int unsigned     cyc;
        logic [7:0]      cmd;
        logic [3:0]      len;
        logic [63:0]     payload;
    } exp_t;

    exp_t        sb[$];
    int          n_vec;
    int          n_fail;
    int unsigned pos_cnt;
    int unsigned last_drive;
    logic [7:0]  m_cmd;
    logic [3:0]  m_len;
    logic [63:0] m_payload;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pos_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_dv      = 1'b1;
        rx_byte    = b;
        last_drive = pos_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            rx_dv = 1'b0;
        end
    endtask

    task automatic push(input int kind, input int unsigned cyc);
        exp_t e;
        e.kind    = kind;
        e.cyc     = cyc;
        e.cmd     = m_cmd;
        e.len     = m_len;
        e.payload = m_payload;
        sb.push_back(e);
    endtask

    task automatic good(input logic [7:0] c, input logic [3:0] l, input logic [63:0] p);
        m_cmd     = c;
        m_len     = l;
        m_payload = p;
        push(0, last_drive + 1);
    endtask

    // Monitor: each result pulse must match the queue head in kind and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int   kind;
            exp_t e;
            logic [3:0] pulses;
            pulses = {frame_valid, err_chk, err_len, err_timeout};
            check("pulse_onehot", 64'($countones(pulses) <= 1), 64'd1);
            if (pulses != 4'b0) begin
                kind = frame_valid ? 0 : err_chk ? 1 : err_len ? 2 : 3;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, pos_cnt);
                end else begin
                    e = sb.pop_front();
                    $display("event kind=%0d cycle=%0d cmd=%h len=%0d payload=%h", kind, pos_cnt, cmd, len, payload);
                    check("pulse_kind", 64'(kind), 64'(e.kind));
                    check("pulse_cycle", 64'(pos_cnt), 64'(e.cyc));
                    check("cmd", 64'(cmd), 64'(e.cmd));
                    check("len", 64'(len), 64'(e.len));
                    check("payload", payload, e.payload);
                end
            end else if (sb.size() > 0 && sb[0].cyc < pos_cnt) begin
                e = sb.pop_front();
                n_vec++;
                n_fail++;
                $display("FAIL missing_pulse: got none by cycle %0d, expected kind %0d at cycle %0d", pos_cnt, e.kind, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d;
        n_vec = 0; n_fail = 0; pos_cnt = 0; last_drive = 0;
        m_cmd = '0; m_len = '0; m_payload = '0;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {frame_valid, err_chk, err_len, err_timeout, busy, len, cmd}, '0);
        check("rst_payload", payload, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame: 10+02+33+44 = 89.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44);
        check("busy_midframe", 64'(busy), 64'd1);
        send(8'h89);
        good(8'h10, 4'd2, 64'h4433);
        idle(3);
        check("busy_after_good", 64'(busy), 64'd0);

        // Bad checksum, then a back-to-back frame with LEN=0.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h8A);
        push(1, last_drive + 1);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        good(8'h01, 4'd0, 64'h0);
        idle(3);

        // Junk then LEN above MAX_LEN.
        send(8'h00); send(8'hFF);
        idle(1);
        check("busy_after_junk", 64'(busy), 64'd0);
        send(8'hA5); send(8'h20); send(8'h09);
        push(2, last_drive + 1);
        idle(3);
        check("busy_after_len_err", 64'(busy), 64'd0);

        // Checksum wrap and SYNC value inside payload/CHK.
        send(8'hA5); send(8'hFF); send(8'h01); send(8'hA5); send(8'hA5);
        good(8'hFF, 4'd1, 64'hA5);
        idle(3);

        // Full-length payload: 22+08+(1..8)=4E.
        send(8'hA5); send(8'h22); send(8'h08);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h4E);
        good(8'h22, 4'd8, 64'h0807060504030201);
        idle(2);
        // Shorter frame must clear the upper bytes.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h89);
        good(8'h10, 4'd2, 64'h4433);
        idle(3);

        // Byte on the exact timeout cycle is accepted.
        send(8'hA5); send(8'h10);
        d = last_drive;
        idle(1);
        while (pos_cnt < d + T_OUT - 2) idle(1);
        send(8'h00); send(8'h10);
        good(8'h10, 4'd0, 64'h0);
        idle(3);

        // Silence after CMD: timeout T_OUT-1 clocks after the last strobe.
        send(8'hA5); send(8'h10);
        push(3, last_drive + T_OUT);
        idle(T_OUT + 5);
        check("busy_after_timeout", 64'(busy), 64'd0);

        // Asynchronous reset mid-frame.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33);
        idle(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {frame_valid, err_chk, err_len, err_timeout, busy, len, cmd}, '0);
        check("midrst_payload", payload, '0);
        m_cmd = '0; m_len = '0; m_payload = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h89);
        good(8'h10, 4'd2, 64'h4433);
        idle(5);

        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
